opb_register_bank_simulink2ppc: RTL

//  Parametrised successor to the single-word simulink2ppc register. Captures N_CHANNELS user words

---
 rtl/opb_register_bank_simulink2ppc.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/opb_register_bank_simulink2ppc.sv
// OPB slave register bank: snapshots N_CHANNELS user words (continuous or armed one-shot) for PPC readback.
// Optional build macro COHERENT_READ_EN: a CH0 read latches a read shadow that CH1..CH(N-1) reads return.
module opb_register_bank_simulink2ppc #(
    parameter logic [0:31] C_BASEADDR   = 32'h00000000,
    parameter logic [0:31] C_HIGHADDR   = 32'h000000FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5",
    parameter int          N_CHANNELS   = 4
) (
    input  logic                                 OPB_Clk,
    input  logic                                 OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]              OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]            OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]              OPB_DBus,
    input  logic                                 OPB_RNW,
    input  logic                                 OPB_select,
    input  logic                                 OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]              Sl_DBus,
    output logic                                 Sl_xferAck,
    output logic                                 Sl_errAck,
    output logic                                 Sl_retry,
    output logic                                 Sl_toutSup,
    input  logic [N_CHANNELS*C_OPB_DWIDTH-1:0]   user_data_in,
    input  logic                                 user_valid,
    output logic                                 capture_done
);

    localparam int AW = C_OPB_AWIDTH;
    localparam int DW = C_OPB_DWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t          state_r;
    logic            mode_r;
    logic            armed_r;
    logic            done_r;
    logic [15:0]     cnt_r;
    logic [DW-1:0]   snap_r [N_CHANNELS];

    logic [5:0]      off_s;
    logic            bus_go_s;
    logic            ctrl_wr_s;
    logic            wr_mode_s;
    logic            arm_s;
    logic            mode_chg_s;
    logic            cap_cont_s;
    logic            cap_shot_s;
    logic            load_s;
    logic [DW-1:0]   rd_data_s;
    logic            unused_s;

    assign Sl_errAck    = 1'b0;
    assign Sl_retry     = 1'b0;
    assign Sl_toutSup   = 1'b0;
    assign capture_done = done_r;

    assign unused_s = ^{OPB_BE, OPB_seqAddr, OPB_ABus[AW-2:AW-1], C_HIGHADDR, C_FAMILY};

    // Word offset within the 256-byte window; only the top 24 address bits select the bank.
    assign off_s      = OPB_ABus[AW-8:AW-3];
    assign bus_go_s   = OPB_select && (state_r == ST_IDLE) &&
                        (OPB_ABus[0:AW-9] == C_BASEADDR[0:AW-9]);
    assign ctrl_wr_s  = bus_go_s && !OPB_RNW && (off_s == 6'd0);
    assign wr_mode_s  = OPB_DBus[DW-1];
    assign mode_chg_s = ctrl_wr_s && (wr_mode_s != mode_r);
    // Arm only matters when the resulting mode is one-shot; an arm write blocks capture on its own edge.
    assign arm_s      = ctrl_wr_s && OPB_DBus[DW-2] && wr_mode_s;
    assign cap_cont_s = !mode_r && user_valid;
    assign cap_shot_s = mode_r && armed_r && user_valid && !arm_s;
    assign load_s     = cap_cont_s || cap_shot_s;

`ifdef COHERENT_READ_EN
    logic [DW-1:0] shadow_r [N_CHANNELS];

    // Read shadow: every snapshot copied when CH0 is read.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            for (int i = 0; i < N_CHANNELS; i++) shadow_r[i] <= {DW{1'b0}};
        end else if (bus_go_s && OPB_RNW && (off_s == 6'd2)) begin
            for (int i = 0; i < N_CHANNELS; i++) shadow_r[i] <= snap_r[i];
        end else begin
            for (int i = 0; i < N_CHANNELS; i++) shadow_r[i] <= shadow_r[i];
        end
    end
`endif

    // Read data mux over the register map.
    always_comb begin
        rd_data_s = {DW{1'b0}};
        case (off_s)
            6'd0: begin
                rd_data_s[0] = mode_r;
            end
            6'd1: begin
                rd_data_s[31:16] = cnt_r;
                rd_data_s[0]     = done_r;
            end
            default: begin
                for (int i = 0; i < N_CHANNELS; i++) begin
                    if (off_s == 6'(i + 2)) begin
`ifdef COHERENT_READ_EN
                        if (i == 0) begin
                            rd_data_s = snap_r[i];
                        end else begin
                            rd_data_s = shadow_r[i];
                        end
`else
                        rd_data_s = snap_r[i];
`endif
                    end else begin
                        rd_data_s = rd_data_s;
                    end
                end
            end
        endcase
    end

    // Bus FSM: one ack per select assertion, read data only present during the ack cycle.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_r    <= ST_IDLE;
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= {DW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus_go_s) begin
                        state_r    <= ST_ACK;
                        Sl_xferAck <= 1'b1;
                        Sl_DBus    <= OPB_RNW ? rd_data_s : {DW{1'b0}};
                    end else begin
                        state_r    <= ST_IDLE;
                        Sl_xferAck <= 1'b0;
                        Sl_DBus    <= {DW{1'b0}};
                    end
                end
                ST_ACK: begin
                    state_r    <= ST_WAIT;
                    Sl_xferAck <= 1'b0;
                    Sl_DBus    <= {DW{1'b0}};
                end
                ST_WAIT: begin
                    state_r    <= OPB_select ? ST_WAIT : ST_IDLE;
                    Sl_xferAck <= 1'b0;
                    Sl_DBus    <= {DW{1'b0}};
                end
                default: begin
                    state_r    <= ST_IDLE;
                    Sl_xferAck <= 1'b0;
                    Sl_DBus    <= {DW{1'b0}};
                end
            endcase
        end
    end

    // Control, status and snapshot registers.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            mode_r  <= 1'b0;
            armed_r <= 1'b0;
            done_r  <= 1'b0;
            cnt_r   <= 16'd0;
            for (int i = 0; i < N_CHANNELS; i++) snap_r[i] <= {DW{1'b0}};
        end else begin
            mode_r <= ctrl_wr_s ? wr_mode_s : mode_r;

            if (arm_s) begin
                armed_r <= 1'b1;
            end else if (mode_chg_s || cap_shot_s) begin
                armed_r <= 1'b0;
            end else begin
                armed_r <= armed_r;
            end

            if (arm_s || mode_chg_s) begin
                done_r <= 1'b0;
            end else if (cap_shot_s) begin
                done_r <= 1'b1;
            end else begin
                done_r <= done_r;
            end

            if (load_s) begin
                cnt_r <= cnt_r + 16'd1;
                for (int i = 0; i < N_CHANNELS; i++) snap_r[i] <= user_data_in[DW*i +: DW];
            end else begin
                cnt_r <= cnt_r;
                for (int i = 0; i < N_CHANNELS; i++) snap_r[i] <= snap_r[i];
            end
        end
    end

endmodule
